ddr2_init_refresh_seq: RTL

Command sequencer that owns the DDR2 command bus (CKE, CS#, RAS#, CAS#, WE#, BA, A) during power-up initialization and periodic auto-refresh. It drives the JEDEC init sequence for the x16 DDR2 device (32M×16, 4 banks, 13-bit address) and then schedules refreshes through a request/acknowledge handshake with the main read/write scheduler. It sits between that scheduler and the command-pin mux feeding the memory. While it owns the bus (init, or a refresh with `ref_busy`=1), the scheduler must drive no commands.

---
 rtl/ddr2_init_refresh_seq.sv | 283 ++++++++++++++++++++++++++++
 1 files changed

// File: rtl/ddr2_init_refresh_seq.sv
// DDR2 power-up initialization and auto-refresh command sequencer.
// Owns the command bus during the JEDEC init sequence, then issues
// PRE-all + REFRESH pairs whenever the scheduler acknowledges a pending
// refresh request.
//
// Handshake: ref_req is a level meaning "at least one refresh is owed".
// The scheduler answers with ref_ack=1 once all banks are closed; an ack
// is accepted only in a cycle where ref_req=1 and ref_busy=0, and from
// the following cycle the sequencer drives the bus (ref_busy=1) until the
// REFRESH recovery time has elapsed.
//
// Timing model: each state lasts a fixed number of cycles. The state's
// command is driven only in its first cycle (segment counter == 0); the
// remaining cycles are NOPs, so the next command lands exactly the
// required delay later.
module ddr2_init_refresh_seq #(
    parameter int unsigned T_PWRUP = 100,
    parameter int unsigned T_CKE   = 108,
    parameter int unsigned T_RP    = 4,
    parameter int unsigned T_MRD   = 2,
    parameter int unsigned T_RFC   = 28,
    parameter int unsigned T_DLL   = 200,
    parameter int unsigned T_REFI  = 2075,
    parameter logic [12:0] MR_VAL  = 13'h0232,
    parameter logic [12:0] EMR_VAL = 13'h0004
) (
    input  logic        clk,
    input  logic        reset,
    output logic        cke,
    output logic        csbar,
    output logic        rasbar,
    output logic        casbar,
    output logic        webar,
    output logic [1:0]  ba,
    output logic [12:0] a,
    output logic        init_done,
    output logic        ref_req,
    output logic        ref_urgent,
    input  logic        ref_ack,
    output logic        ref_busy
);

    // Width of the segment and refresh-interval counters.
    localparam int CW = 16;

    // Command encodings {cs#, ras#, cas#, we#}.
    localparam logic [3:0] CMD_NOP = 4'b0111;
    localparam logic [3:0] CMD_PRE = 4'b0010;
    localparam logic [3:0] CMD_REF = 4'b0001;
    localparam logic [3:0] CMD_LMR = 4'b0000;

    // Mode register images with the bits this block controls forced.
    localparam logic [12:0] MR_DLL_RST   = MR_VAL  | 13'h0100;
    localparam logic [12:0] MR_DLL_OFF   = MR_VAL  & ~13'h0100;
    localparam logic [12:0] EMR_OCD_DFLT = EMR_VAL | 13'h0380;
    localparam logic [12:0] EMR_OCD_OFF  = EMR_VAL & ~13'h0380;

    // Pending-refresh saturation level.
    localparam logic [3:0] PEND_MAX = 4'd8;

    typedef enum logic [3:0] {
        S_PWRUP,
        S_CKEW,
        S_PRE1,
        S_EMR2,
        S_EMR3,
        S_EMR1,
        S_MRDLL,
        S_PRE2,
        S_REF1,
        S_REF2,
        S_MR,
        S_OCDD,
        S_OCDX,
        S_IDLE,
        S_RPRE,
        S_RREF
    } state_t;

    state_t         state_q, state_d;
    logic [CW-1:0]  cnt_q, cnt_d;
    logic [CW-1:0]  tmr_q, tmr_d;
    logic [3:0]     pend_q, pend_d;

    logic           cke_q, cke_d;
    logic [3:0]     cmd_q, cmd_d;
    logic [1:0]     ba_q, ba_d;
    logic [12:0]    a_q, a_d;
    logic           init_done_q, init_done_d;
    logic           ref_req_q, ref_req_d;
    logic           ref_urgent_q, ref_urgent_d;
    logic           ref_busy_q, ref_busy_d;

    logic [CW-1:0]  seg_last;
    logic           seg_end;
    logic           ack_take;
    logic           ref_tick;
    logic           ref_done;

    // Last segment-counter value of each state (state length minus one).
    function automatic logic [CW-1:0] last_of(input state_t s);
        logic [CW-1:0] r;
        r = '0;
        case (s)
            S_PWRUP:                                   r = CW'(T_PWRUP - 1);
            S_CKEW:                                    r = CW'(T_CKE - 1);
            S_PRE1, S_PRE2, S_RPRE:                    r = CW'(T_RP - 1);
            S_EMR2, S_EMR3, S_EMR1, S_MRDLL,
            S_OCDD, S_OCDX:                            r = CW'(T_MRD - 1);
            S_REF1, S_REF2, S_RREF:                    r = CW'(T_RFC - 1);
            S_MR:                                      r = CW'(T_DLL - 1);
            default:                                   r = '0;
        endcase
        return r;
    endfunction

    // Successor of each timed state once its segment has elapsed.
    function automatic state_t next_of(input state_t s);
        state_t r;
        r = S_IDLE;
        case (s)
            S_PWRUP: r = S_CKEW;
            S_CKEW:  r = S_PRE1;
            S_PRE1:  r = S_EMR2;
            S_EMR2:  r = S_EMR3;
            S_EMR3:  r = S_EMR1;
            S_EMR1:  r = S_MRDLL;
            S_MRDLL: r = S_PRE2;
            S_PRE2:  r = S_REF1;
            S_REF1:  r = S_REF2;
            S_REF2:  r = S_MR;
            S_MR:    r = S_OCDD;
            S_OCDD:  r = S_OCDX;
            S_OCDX:  r = S_IDLE;
            S_RPRE:  r = S_RREF;
            S_RREF:  r = S_IDLE;
            default: r = S_IDLE;
        endcase
        return r;
    endfunction

    // Next-state logic for the combined init / refresh sequencer.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        seg_last = last_of(state_q);
        seg_end  = (cnt_q == seg_last);
        ack_take = 1'b0;
        ref_done = 1'b0;
        if (state_q == S_IDLE) begin
            cnt_d = '0;
            if (ref_ack && ref_req_q) begin
                ack_take = 1'b1;
                state_d  = S_RPRE;
            end
        end else if (seg_end) begin
            cnt_d    = '0;
            state_d  = next_of(state_q);
            ref_done = (state_q == S_RREF);
        end else begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    // Refresh interval timer and pending-refresh bookkeeping.
    always_comb begin
        tmr_d    = tmr_q;
        pend_d   = pend_q;
        ref_tick = 1'b0;
        if (init_done_q) begin
            if (tmr_q == '0) begin
                ref_tick = 1'b1;
                tmr_d    = CW'(T_REFI - 1);
            end else begin
                tmr_d = tmr_q - 1'b1;
            end
        end
        // Expiry and completion in the same cycle cancel out.
        if (ref_tick && !ref_done) begin
            if (pend_q != PEND_MAX) begin
                pend_d = pend_q + 4'd1;
            end
        end else if (ref_done && !ref_tick) begin
            pend_d = pend_q - 4'd1;
        end
    end

    // Output decode from the upcoming state so every pin is registered.
    always_comb begin
        cke_d        = (state_d != S_PWRUP);
        cmd_d        = CMD_NOP;
        ba_d         = 2'd0;
        a_d          = 13'h0000;
        init_done_d  = (state_d == S_IDLE) || (state_d == S_RPRE) || (state_d == S_RREF);
        ref_busy_d   = (state_d == S_RPRE) || (state_d == S_RREF);
        ref_req_d    = (pend_d != 4'd0);
        ref_urgent_d = (pend_d == PEND_MAX);
        if (cnt_d == '0) begin
            case (state_d)
                S_PRE1, S_PRE2, S_RPRE: begin
                    cmd_d  = CMD_PRE;
                    a_d[10] = 1'b1;
                end
                S_REF1, S_REF2, S_RREF: begin
                    cmd_d = CMD_REF;
                end
                S_EMR2: begin
                    cmd_d = CMD_LMR;
                    ba_d  = 2'd2;
                end
                S_EMR3: begin
                    cmd_d = CMD_LMR;
                    ba_d  = 2'd3;
                end
                S_EMR1, S_OCDX: begin
                    cmd_d = CMD_LMR;
                    ba_d  = 2'd1;
                    a_d   = EMR_OCD_OFF;
                end
                S_OCDD: begin
                    cmd_d = CMD_LMR;
                    ba_d  = 2'd1;
                    a_d   = EMR_OCD_DFLT;
                end
                S_MRDLL: begin
                    cmd_d = CMD_LMR;
                    a_d   = MR_DLL_RST;
                end
                S_MR: begin
                    cmd_d = CMD_LMR;
                    a_d   = MR_DLL_OFF;
                end
                default: begin
                    cmd_d = CMD_NOP;
                end
            endcase
        end
    end

    // State, counters and registered outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= S_PWRUP;
            cnt_q        <= '0;
            tmr_q        <= CW'(T_REFI);
            pend_q       <= 4'd0;
            cke_q        <= 1'b0;
            cmd_q        <= CMD_NOP;
            ba_q         <= 2'd0;
            a_q          <= 13'h0000;
            init_done_q  <= 1'b0;
            ref_req_q    <= 1'b0;
            ref_urgent_q <= 1'b0;
            ref_busy_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            tmr_q        <= tmr_d;
            pend_q       <= pend_d;
            cke_q        <= cke_d;
            cmd_q        <= cmd_d;
            ba_q         <= ba_d;
            a_q          <= a_d;
            init_done_q  <= init_done_d;
            ref_req_q    <= ref_req_d;
            ref_urgent_q <= ref_urgent_d;
            ref_busy_q   <= ref_busy_d;
        end
    end

    assign cke        = cke_q;
    assign csbar      = cmd_q[3];
    assign rasbar     = cmd_q[2];
    assign casbar     = cmd_q[1];
    assign webar      = cmd_q[0];
    assign ba         = ba_q;
    assign a          = a_q;
    assign init_done  = init_done_q;
    assign ref_req    = ref_req_q;
    assign ref_urgent = ref_urgent_q;
    assign ref_busy   = ref_busy_q;

endmodule
